// File: rtl/onehot_wren_check_pkg.sv
// Shared types for the one-hot write-enable glitch detector.
// Collects the individual violation flags so the top can reduce them in one place.
package onehot_wren_check_pkg;

    typedef struct packed {
        logic multi;
        logic addr;
        logic en;
    } err_vec_t;

    function automatic logic err_any(input err_vec_t errs);
        return errs.multi | errs.addr | errs.en;
    endfunction

endpackage

// File: rtl/onehot_wren_check_buf.sv
// Identity buffer for the strobe vector; kept as a distinct cell so the checker
// observes the physical strobe wires rather than a copy merged by synthesis.
(* keep = "true", dont_touch = "true" *)
module onehot_buf #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] in_i,
    output logic [Width-1:0] out_o
);

    (* keep = "true", dont_touch = "true" *)
    logic [Width-1:0] buf_w;

    assign buf_w = in_i;
    assign out_o = buf_w;

endmodule

// File: rtl/onehot_wren_check.sv
// Checks a decoded write-enable strobe for one-hot-ness and consistency with the
// address/enable that produced it; raises a combinational and a sticky error.
module onehot_wren_check
    import onehot_wren_check_pkg::*;
#(
    parameter int AddrWidth   = 5,
    parameter int OneHotWidth = 2 ** AddrWidth,
    parameter bit AddrCheck   = 1'b1,
    parameter bit EnableCheck = 1'b1,
    parameter bit StrictCheck = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [OneHotWidth-1:0] oh_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   en_i,
    output logic                   err_o,
    output logic                   err_sticky_o
);

    localparam int Levels    = (OneHotWidth > 1) ? $clog2(OneHotWidth) : 0;
    localparam int NumLeaves = 1 << Levels;
    localparam int AddrSpan  = 1 << AddrWidth;
    localparam logic [AddrWidth:0] OhWidthA = (AddrWidth + 1)'(OneHotWidth);

    if (OneHotWidth > AddrSpan) begin : g_bad_width
        $error("onehot_wren_check: OneHotWidth exceeds 2**AddrWidth");
    end
    if (StrictCheck && !AddrCheck && !EnableCheck) begin : g_bad_strict
        $error("onehot_wren_check: StrictCheck needs AddrCheck or EnableCheck");
    end

    logic [OneHotWidth-1:0] oh_b;

    onehot_buf #(
        .Width(OneHotWidth)
    ) u_onehot_buf (
        .in_i (oh_i),
        .out_o(oh_b)
    );

    logic [NumLeaves-1:0] leaf_any;
    logic [AddrSpan-1:0]  oh_pad;

    // NOTE: defaults first, then the partial overwrite; without the default the
    // padding bits would hold their old value and infer a latch.
    always_comb begin
        leaf_any = '0;
        leaf_any[OneHotWidth-1:0] = oh_b;
        oh_pad = '0;
        oh_pad[OneHotWidth-1:0] = oh_b;
    end

    // Balanced tree: each node carries "any set" and "two or more set" of its subtree.
    for (genvar l = 0; l < Levels; l++) begin : g_level
        localparam int Nodes = NumLeaves >> (l + 1);
        logic [2*Nodes-1:0] any_in;
        logic [2*Nodes-1:0] two_in;
        logic [Nodes-1:0]   any_out;
        logic [Nodes-1:0]   two_out;

        if (l == 0) begin : g_first
            assign any_in = leaf_any;
            assign two_in = '0;
        end else begin : g_next
            assign any_in = g_level[l-1].any_out;
            assign two_in = g_level[l-1].two_out;
        end

        for (genvar k = 0; k < Nodes; k++) begin : g_node
            assign any_out[k] = any_in[2*k] | any_in[2*k+1];
            assign two_out[k] = two_in[2*k] | two_in[2*k+1]
                              | (any_in[2*k] & any_in[2*k+1]);
        end
    end

    logic any_hot;
    logic multi_hot;

    if (Levels == 0) begin : g_root_leaf
        assign any_hot   = leaf_any[0];
        assign multi_hot = 1'b0;
    end else begin : g_root_tree
        assign any_hot   = g_level[Levels-1].any_out[0];
        assign multi_hot = g_level[Levels-1].two_out[0];
    end

    logic     addr_in_range;
    logic     sel_hot;
    err_vec_t errs;

    assign addr_in_range = ({1'b0, addr_i} < OhWidthA);
    assign sel_hot       = oh_pad[addr_i];

    always_comb begin
        errs       = '0;
        errs.multi = multi_hot;
        if (AddrCheck) begin
            errs.addr = (any_hot && !sel_hot)
                      || (any_hot && !addr_in_range)
                      || (StrictCheck && sel_hot && !en_i);
        end
        if (EnableCheck) begin
            errs.en = (any_hot && !en_i)
                    || (StrictCheck && en_i && !any_hot);
        end
    end

    assign err_o = err_any(errs);

    logic err_sticky_d;
    logic err_sticky_q;

    assign err_sticky_d = err_sticky_q | err_o;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_onehot_wren_check.sv
// Directed and randomised bench for onehot_wren_check (AddrWidth = 5, all checks on).
// Expected values come from a popcount-based reference model via a scoreboard queue.
module tb_onehot_wren_check;

    localparam int AW = 5;
    localparam int OW = 32;

    typedef struct {
        string tag;
        logic  val;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [OW-1:0] oh_i  = '0;
    logic [AW-1:0] addr_i = '0;
    logic          en_i  = 1'b0;
    logic          err_o;
    logic          err_sticky_o;

    int   checks = 0;
    int   errors = 0;
    logic sticky_m = 1'b0;
    exp_t exp_q[$];

    onehot_wren_check #(
        .AddrWidth  (AW),
        .OneHotWidth(OW),
        .AddrCheck  (1'b1),
        .EnableCheck(1'b1),
        .StrictCheck(1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .oh_i        (oh_i),
        .addr_i      (addr_i),
        .en_i        (en_i),
        .err_o       (err_o),
        .err_sticky_o(err_sticky_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic model_err(input logic [OW-1:0] oh, input logic [AW-1:0] addr,
                                       input logic en);
        logic any, multi, sel, a_err, e_err;
        any   = (oh != '0);
        multi = ($countones(oh) > 1);
        sel   = oh[addr];
        a_err = (any && !sel) || (sel && !en);
        e_err = (any && !en) || (en && !any);
        return multi | a_err | e_err;
    endfunction

    task automatic check_pop(input logic observed);
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%b", observed);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (observed === e.val) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", e.tag, observed, e.val);
        end
    endtask

    task automatic step(input logic [OW-1:0] oh, input logic [AW-1:0] addr,
                        input logic en, input logic rst, input string tag);
        logic e_err;
        @(negedge clk_i);
        oh_i   = oh;
        addr_i = addr;
        en_i   = en;
        rst_i  = rst;
        e_err  = model_err(oh, addr, en);
        exp_q.push_back('{tag: {tag, "_err"}, val: e_err});
        #1;
        check_pop(err_o);
        @(posedge clk_i);
        sticky_m = rst ? 1'b0 : (sticky_m | e_err);
        exp_q.push_back('{tag: {tag, "_sticky"}, val: sticky_m});
        #1;
        check_pop(err_sticky_o);
    endtask

    initial begin
        logic [OW-1:0] r_oh;
        logic [AW-1:0] r_addr;
        logic          r_en;

        step(32'h0, 5'd0, 1'b0, 1'b1, "reset");
        step(32'h0000_8000, 5'd15, 1'b1, 1'b0, "legal_write");
        step(32'h0, 5'd7, 1'b0, 1'b0, "idle");
        step(32'h8000_0000, 5'd31, 1'b1, 1'b0, "legal_top");
        step(32'h0000_0001, 5'd0, 1'b1, 1'b0, "legal_bottom");
        step(32'h0000_0018, 5'd3, 1'b1, 1'b0, "double_strobe");
        step(32'h0000_8000, 5'd15, 1'b1, 1'b0, "held_after_legal");
        step(32'h0, 5'd7, 1'b0, 1'b0, "held_idle");
        step(32'h0000_0010, 5'd3, 1'b1, 1'b0, "addr_mismatch");
        step(32'h0000_0004, 5'd2, 1'b0, 1'b0, "spurious_strobe");
        step(32'h0, 5'd2, 1'b1, 1'b0, "missing_strobe");
        step(32'h0000_0018, 5'd3, 1'b1, 1'b1, "reset_while_illegal");
        step(32'h0000_0018, 5'd3, 1'b1, 1'b0, "resets_after_release");
        step(32'h0, 5'd0, 1'b0, 1'b1, "reset_clean");
        step(32'h8000_0001, 5'd31, 1'b1, 1'b0, "far_double");
        step(32'h0, 5'd0, 1'b0, 1'b1, "reset_again");
        step(32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0, "all_hot");
        step(32'h0, 5'd0, 1'b0, 1'b1, "reset_before_random");

        for (int i = 0; i < 40; i++) begin
            r_addr = AW'($urandom_range(0, OW - 1));
            r_en   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       r_oh = '0;
                1:       r_oh = OW'(1) << r_addr;
                2:       r_oh = OW'(1) << $urandom_range(0, OW - 1);
                default: r_oh = OW'($urandom);
            endcase
            step(r_oh, r_addr, r_en, (i % 10) == 9, "random");
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
